scan_chain_ctrl: RTL and testbench

- Sequences a scan chain for HardSnap state snapshot and restore.
- Takes one command at a time (operation, bit length) and drives scan_enable, scan_ck_enable and scan_input.
- Captures scan_output bit-serially, packing and unpacking 32-bit words on valid/ready streams.
- Sits between the AXI-facing register/DMA logic and the scan-instrumented design under test.

---
 rtl/scan_chain_ctrl_if.sv | 40 ++++
 rtl/scan_chain_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Bundle of command, data-stream, scan-chain and status signals for
// scan_chain_ctrl. The master side is the register/DMA logic plus the
// scan-instrumented design (it drives scan_output). The slave side is the
// controller itself.
interface scan_chain_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              scan_enable;
    logic              scan_ck_enable;
    logic              scan_input;
    logic              scan_output;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [15:0]       crc_out;

    modport master (
        output cmd_valid, cmd_op, cmd_len, abort, in_data, in_valid, out_ready, scan_output,
        input  cmd_ready, in_ready, out_data, out_valid, scan_enable, scan_ck_enable,
               scan_input, busy, done, aborted, crc_out
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, abort, in_data, in_valid, out_ready, scan_output,
        output cmd_ready, in_ready, out_data, out_valid, scan_enable, scan_ck_enable,
               scan_input, busy, done, aborted, crc_out
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences a scan chain for state snapshot / restore.
// One command (op, bit length) at a time; bits are shifted LSB first out of
// 32-bit input words and packed LSB first into 32-bit output words.
// scan_ck_enable and scan_input are combinational: in DUMP the chain output
// is fed straight back into the chain input in the same strobe cycle, and an
// abort must freeze the chain in the very cycle it is raised.
// Optional feature macro: SCAN_CTRL_CRC_EN (CRC-16-CCITT over captured bits
// on crc_out). Without it crc_out is tied to zero.
module scan_chain_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    scan_chain_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] OP_DUMP = 2'd0;
    localparam logic [1:0] OP_SWAP = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [1:0]        r_op;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;        // bits strobed so far in this command
    logic [DATA_W-1:0] r_in_buf;     // current input word, consumed from bit 0
    logic              r_in_full;
    logic [DATA_W-1:0] r_acc;        // partially packed output word
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_aborted;

    logic              w_accept;
    logic              w_active;
    logic              w_need_in;
    logic              w_need_out;
    logic              w_bits_left;
    logic              w_last;
    logic              w_word_end;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_strobe;
    logic              w_scan_bit;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_cmd_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_scan_enable;

    // Per-cycle qualifiers: handshakes, word boundaries and the shift strobe
    always_comb begin
        w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
        w_active    = (r_state == S_PREP) || (r_state == S_SHIFT);
        w_need_in   = (r_op == OP_SWAP) || (r_op == OP_LOAD);
        w_need_out  = (r_op == OP_DUMP) || (r_op == OP_SWAP);
        w_bits_left = (r_cnt < r_len);
        w_last      = (r_cnt == (r_len - LEN_ONE));
        w_word_end  = (&r_cnt[IDX_W-1:0]) || w_last;
        w_in_ready  = (r_state == S_SHIFT) && w_need_in && !r_in_full && w_bits_left;
        w_in_fire   = w_in_ready && bus.in_valid;
        w_out_fire  = r_out_valid && bus.out_ready;
        // The chain only moves when a source bit exists, the output word
        // has room, and no abort is pending; otherwise it stays frozen.
        w_strobe    = (r_state == S_SHIFT) && w_bits_left
                      && (!w_need_in || r_in_full)
                      && (!w_need_out || !r_out_valid)
                      && !bus.abort;
        // DUMP recirculates the captured bit so the chain is left intact.
        w_scan_bit  = w_need_in ? r_in_buf[0] : bus.scan_output;
        w_acc_next  = r_acc | ({{(DATA_W-1){1'b0}}, bus.scan_output} << r_cnt[IDX_W-1:0]);
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic and state-decoded status outputs
    always_comb begin
        w_state_next  = r_state;
        w_cmd_ready   = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_scan_enable = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    // Reserved ops and empty commands finish without shifting.
                    if ((bus.cmd_op == OP_RSVD) || (bus.cmd_len == LEN_ZERO)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_PREP;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_PREP: begin
                w_busy        = 1'b1;
                w_scan_enable = 1'b1;
                if (bus.abort) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy        = 1'b1;
                w_scan_enable = 1'b1;
                if (bus.abort) begin
                    w_state_next = S_DONE;
                end else if (!w_bits_left && (!r_out_valid || bus.out_ready)) begin
                    // All bits shifted and the last word leaves this cycle.
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, bit counter, input word unpacking and output word packing
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_op        <= 2'd0;
            r_len       <= LEN_ZERO;
            r_cnt       <= LEN_ZERO;
            r_in_buf    <= {DATA_W{1'b0}};
            r_in_full   <= 1'b0;
            r_acc       <= {DATA_W{1'b0}};
            r_out_data  <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
            r_aborted   <= 1'b0;
        end else if (w_accept) begin
            r_op        <= bus.cmd_op;
            r_len       <= bus.cmd_len;
            r_cnt       <= LEN_ZERO;
            r_aborted   <= (bus.cmd_op == OP_RSVD);
            r_in_buf    <= {DATA_W{1'b0}};
            r_in_full   <= 1'b0;
            r_acc       <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
        end else if (w_active && bus.abort) begin
            // Drop any partial or pending output and any unused input word.
            r_aborted   <= 1'b1;
            r_in_full   <= 1'b0;
            r_acc       <= {DATA_W{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_in_buf  <= bus.in_data;
                r_in_full <= 1'b1;
            end
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_strobe) begin
                r_cnt <= r_cnt + LEN_ONE;
                if (w_need_in) begin
                    r_in_buf <= {1'b0, r_in_buf[DATA_W-1:1]};
                    if (w_word_end) begin
                        r_in_full <= 1'b0;
                    end
                end
                if (w_need_out) begin
                    if (w_word_end) begin
                        // Upper bits of a final partial word are already zero.
                        r_out_data  <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_acc       <= {DATA_W{1'b0}};
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end
            end
        end
    end

`ifdef SCAN_CTRL_CRC_EN
    logic [15:0] r_crc;

    // One MSB-first CRC-16-CCITT (poly 0x1021) step for a single bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // CRC over every bit captured from the chain in DUMP/SWAP
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_crc <= 16'h0000;
        end else if (w_accept) begin
            r_crc <= 16'hFFFF;
        end else if (w_strobe && w_need_out) begin
            r_crc <= crc16_step(r_crc, bus.scan_output);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign bus.crc_out = r_crc;
`else
    assign bus.crc_out = 16'h0000;
`endif

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.aborted        = w_done && r_aborted;
    assign bus.scan_enable    = w_scan_enable;
    assign bus.scan_ck_enable = w_strobe;
    assign bus.scan_input     = w_strobe && w_scan_bit;
    assign bus.in_ready       = w_in_ready;
    assign bus.out_data       = r_out_data;
    assign bus.out_valid      = r_out_valid;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl: a behavioural scan chain model of
// selectable length, a command driver that records what the controller did,
// and per-scenario tasks comparing against expectations queued up front.
module tb_scan_chain_ctrl;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    scan_chain_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) tb_if ();

    scan_chain_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (tb_if)
    );

    int checks   = 0;
    int failures = 0;

    // Chain model: chain[len-1] is the output end, new bits enter at bit 0.
    logic [127:0] r_chain    = 128'd0;
    logic [127:0] chain_mask = 128'hFF;
    logic [127:0] load_val   = 128'd0;
    logic         load_req   = 1'b0;
    int           chain_len  = 8;
    int           strobe_cnt = 0;
    int           full_strobes = 0;

    assign tb_if.scan_output = r_chain[chain_len-1];

    always @(posedge aclk) begin
        if (load_req) begin
            r_chain      <= load_val;
            strobe_cnt   <= 0;
            full_strobes <= 0;
        end else if (tb_if.scan_ck_enable) begin
            r_chain    <= ((r_chain << 1) | {127'd0, tb_if.scan_input}) & chain_mask;
            strobe_cnt <= strobe_cnt + 1;
            if (tb_if.out_valid) full_strobes <= full_strobes + 1;
        end
    end

    // Scoreboard and observations of the last command
    logic [31:0] sb_q[$];
    logic [31:0] got_q[$];
    logic [31:0] in_q[$];
    int          in_hs, done_cyc, last_out_cyc, abort_cyc, unstable, stall_cycles;
    bit          done_seen, done_abt, se_seen, ov_seen, done_next, ready_next;
    logic [15:0] done_crc;

    task automatic load_chain(input logic [127:0] v, input int n);
        chain_len  = n;
        chain_mask = (n == 128) ? {128{1'b1}} : ((128'd1 << n) - 128'd1);
        load_val   = v & chain_mask;
        @(negedge aclk);
        load_req = 1'b1;
        @(negedge aclk);
        load_req = 1'b0;
    endtask

    // Expected output words for a DUMP/SWAP of the given chain contents
    function automatic void push_exp(input logic [127:0] ch, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) begin
            w[k % 32] = ch[n-1-k];
            if ((k % 32) == 31 || k == n - 1) begin
                sb_q.push_back(w);
                w = 32'd0;
            end
        end
    endfunction

    // Drive one command to completion and record what happened (no checking)
    task automatic exec(input logic [1:0] op, input int len, input int stall, input int abort_at);
        int stall_left;
        bit stall_pending, abort_done, prev_hold;
        logic [31:0] prev_data;
        got_q.delete();
        in_hs = 0; done_cyc = -1; last_out_cyc = -1; abort_cyc = -1;
        unstable = 0; stall_cycles = 0;
        done_seen = 0; done_abt = 0; se_seen = 0; ov_seen = 0; done_crc = 16'h0;
        stall_left = 0; stall_pending = (stall > 0); abort_done = 0;
        prev_hold = 0; prev_data = 32'd0;
        @(negedge aclk);
        tb_if.cmd_valid = 1'b1;
        tb_if.cmd_op    = op;
        tb_if.cmd_len   = LEN_W'(len);
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            @(negedge aclk);
            tb_if.cmd_valid = 1'b0;
            if (stall_pending && tb_if.out_valid) begin
                stall_pending = 0;
                stall_left    = stall;
            end
            if (stall_left > 0) begin
                tb_if.out_ready = 1'b0;
                stall_left--;
            end else begin
                tb_if.out_ready = 1'b1;
            end
            tb_if.abort = (abort_at >= 0) && !abort_done && (strobe_cnt == abort_at);
            if (tb_if.abort) begin
                abort_done = 1;
                abort_cyc  = c;
            end
            tb_if.in_valid = (in_q.size() > 0);
            tb_if.in_data  = (in_q.size() > 0) ? in_q[0] : 32'd0;
            #1;
            if (prev_hold && tb_if.out_data !== prev_data) unstable++;
            prev_hold = tb_if.out_valid && !tb_if.out_ready;
            prev_data = tb_if.out_data;
            if (prev_hold) stall_cycles++;
            if (tb_if.scan_enable) se_seen = 1;
            if (tb_if.out_valid) ov_seen = 1;
            if (tb_if.in_valid && tb_if.in_ready) begin
                void'(in_q.pop_front());
                in_hs++;
            end
            if (tb_if.out_valid && tb_if.out_ready) begin
                got_q.push_back(tb_if.out_data);
                last_out_cyc = c;
            end
            if (tb_if.done) begin
                done_seen = 1;
                done_cyc  = c;
                done_abt  = tb_if.aborted;
                done_crc  = tb_if.crc_out;
            end
        end
        @(negedge aclk);
        tb_if.abort     = 1'b0;
        tb_if.in_valid  = 1'b0;
        tb_if.out_ready = 1'b1;
        #1;
        done_next  = tb_if.done;
        ready_next = tb_if.cmd_ready;
    endtask

    task automatic test_reset();
        logic [9:0] st;
        repeat (3) @(negedge aclk);
        #1;
        st = {tb_if.cmd_ready, tb_if.busy, tb_if.done, tb_if.aborted, tb_if.scan_enable,
              tb_if.scan_ck_enable, tb_if.scan_input, tb_if.in_ready, tb_if.out_valid, 1'b0};
        checks++;
        if (st !== 10'b1000000000) begin
            failures++; $display("FAIL reset_status: got %b expected %b", st, 10'b1000000000);
        end
        checks++;
        if (tb_if.out_data !== 32'd0 || tb_if.crc_out !== 16'd0) begin
            failures++; $display("FAIL reset_data: got out_data=%h crc=%h expected 0", tb_if.out_data, tb_if.crc_out);
        end
        areset = 1'b0;
    endtask

    task automatic test_dump();
        logic [31:0] e, a;
        load_chain(128'hA5, 8);
        sb_q.push_back(32'h000000A5);
        exec(2'd0, 8, 0, -1);
        checks++;
        if (got_q.size() != 1) begin
            failures++; $display("FAIL dump_nwords: got %0d expected 1", got_q.size());
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (a !== e) begin failures++; $display("FAIL dump_word: got %h expected %h", a, e); end
        end
        checks++;
        if (strobe_cnt != 8) begin failures++; $display("FAIL dump_strobes: got %0d expected 8", strobe_cnt); end
        checks++;
        if (r_chain[7:0] !== 8'hA5) begin failures++; $display("FAIL dump_chain: got %h expected a5", r_chain[7:0]); end
        checks++;
        if (!done_seen || done_cyc != last_out_cyc + 1 || done_abt) begin
            failures++; $display("FAIL dump_done: got done_cyc=%0d aborted=%0d expected %0d and 0", done_cyc, done_abt, last_out_cyc + 1);
        end
        checks++;
        if (done_next !== 1'b0 || ready_next !== 1'b1) begin
            failures++; $display("FAIL dump_pulse: got done_next=%0d cmd_ready=%0d expected 0 and 1", done_next, ready_next);
        end
    endtask

    task automatic test_load();
        logic [127:0] e;
        logic [31:0]  w [2];
        logic [15:0]  ecrc;
        w[0] = 32'hDEADBEEF;
        w[1] = 32'h000000C3;
        load_chain(128'd0, 40);
        in_q.push_back(w[0]);
        in_q.push_back(w[1]);
        e = 128'd0;
        for (int k = 0; k < 40; k++) e[39-k] = w[k/32][k%32];
        exec(2'd2, 40, 0, -1);
        checks++;
        if (strobe_cnt != 40) begin failures++; $display("FAIL load_strobes: got %0d expected 40", strobe_cnt); end
        checks++;
        if (in_hs != 2) begin failures++; $display("FAIL load_in_hs: got %0d expected 2", in_hs); end
        checks++;
        if (ov_seen) begin failures++; $display("FAIL load_out_valid: got 1 expected 0"); end
        checks++;
        if (r_chain !== e) begin failures++; $display("FAIL load_chain: got %h expected %h", r_chain, e); end
`ifdef SCAN_CTRL_CRC_EN
        ecrc = 16'hFFFF;
`else
        ecrc = 16'h0000;
`endif
        checks++;
        if (!done_seen || done_crc !== ecrc) begin
            failures++; $display("FAIL load_crc: got %h expected %h", done_crc, ecrc);
        end
    endtask

    task automatic test_swap_backpressure();
        logic [127:0] p, e;
        logic [31:0]  w [2];
        logic [31:0]  ew, aw;
        p    = 128'h0123456789ABCDEF;
        w[0] = 32'hCAFEF00D;
        w[1] = 32'h13572468;
        load_chain(p, 64);
        push_exp(p, 64);
        in_q.push_back(w[0]);
        in_q.push_back(w[1]);
        e = 128'd0;
        for (int k = 0; k < 64; k++) e[63-k] = w[k/32][k%32];
        exec(2'd1, 64, 20, -1);
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL swap_nwords: got %0d expected 2", got_q.size()); end
        while (sb_q.size() > 0) begin
            ew = sb_q.pop_front();
            aw = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (aw !== ew) begin failures++; $display("FAIL swap_word: got %h expected %h", aw, ew); end
        end
        checks++;
        if (strobe_cnt != 64 || full_strobes != 0) begin
            failures++; $display("FAIL swap_strobes: got %0d (%0d while full) expected 64 (0)", strobe_cnt, full_strobes);
        end
        checks++;
        if (stall_cycles != 20 || unstable != 0) begin
            failures++; $display("FAIL swap_hold: got stall=%0d unstable=%0d expected 20 and 0", stall_cycles, unstable);
        end
        checks++;
        if (r_chain !== e) begin failures++; $display("FAIL swap_chain: got %h expected %h", r_chain, e); end
    endtask

    task automatic test_zero_len_and_reserved();
        load_chain(128'h5A, 8);
        exec(2'd0, 0, 0, -1);
        checks++;
        if (!done_seen || done_cyc > 1 || done_abt || se_seen || strobe_cnt != 0) begin
            failures++; $display("FAIL zero_len: got done_cyc=%0d aborted=%0d se=%0d strobes=%0d expected <=1,0,0,0",
                                 done_cyc, done_abt, se_seen, strobe_cnt);
        end
        exec(2'd3, 8, 0, -1);
        checks++;
        if (!done_seen || done_cyc != 0 || !done_abt || se_seen || strobe_cnt != 0) begin
            failures++; $display("FAIL reserved_op: got done_cyc=%0d aborted=%0d se=%0d strobes=%0d expected 0,1,0,0",
                                 done_cyc, done_abt, se_seen, strobe_cnt);
        end
    endtask

    task automatic test_abort();
        load_chain(128'h89ABCDEF, 32);
        exec(2'd0, 32, 0, 13);
        checks++;
        if (strobe_cnt != 13) begin failures++; $display("FAIL abort_strobes: got %0d expected 13", strobe_cnt); end
        checks++;
        if (!done_seen || !done_abt || done_cyc != abort_cyc + 1) begin
            failures++; $display("FAIL abort_done: got done_cyc=%0d aborted=%0d expected %0d and 1", done_cyc, done_abt, abort_cyc + 1);
        end
        checks++;
        if (ov_seen || got_q.size() != 0) begin
            failures++; $display("FAIL abort_out: got out_valid_seen=%0d words=%0d expected 0 and 0", ov_seen, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, a;
        load_chain(128'h3C, 8);
        push_exp(128'h3C, 8);
        exec(2'd0, 8, 0, -1);
        load_chain(128'h81, 8);
        push_exp(128'h81, 8);
        exec(2'd0, 8, 0, -1);
        // first command's word was overwritten in got_q; drop its expectation
        void'(sb_q.pop_front());
        e = sb_q.pop_front();
        a = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (a !== e || r_chain[7:0] !== 8'h81) begin
            failures++; $display("FAIL b2b_word: got %h chain %h expected %h chain 81", a, r_chain[7:0], e);
        end
    endtask

`ifdef SCAN_CTRL_CRC_EN
    task automatic test_crc();
        logic [127:0] v;
        logic [31:0]  e, a;
        v = {56'd0, 72'h313233343536373839};
        load_chain(v, 72);
        push_exp(v, 72);
        exec(2'd0, 72, 0, -1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (a !== e) begin failures++; $display("FAIL crc_word: got %h expected %h", a, e); end
        end
        checks++;
        if (!done_seen || done_crc !== 16'h29B1) begin
            failures++; $display("FAIL crc_value: got %h expected 29b1", done_crc);
        end
    endtask
`endif

    task automatic test_reset_mid_shift();
        bit reached;
        load_chain(128'hFEDCBA98, 32);
        @(negedge aclk);
        tb_if.cmd_valid = 1'b1;
        tb_if.cmd_op    = 2'd0;
        tb_if.cmd_len   = LEN_W'(32);
        reached = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge aclk);
            tb_if.cmd_valid = 1'b0;
            if (strobe_cnt >= 5) reached = 1;
        end
        #1;
        checks++;
        if (!reached || tb_if.scan_enable !== 1'b1) begin
            failures++; $display("FAIL midreset_shifting: got scan_enable=%b reached=%0d expected 1 and 1", tb_if.scan_enable, reached);
        end
        areset = 1'b1;
        @(negedge aclk);
        #1;
        checks++;
        if (tb_if.scan_enable !== 1'b0 || tb_if.cmd_ready !== 1'b1 || tb_if.busy !== 1'b0 || tb_if.scan_ck_enable !== 1'b0) begin
            failures++; $display("FAIL midreset_state: got se=%b ready=%b busy=%b ck=%b expected 0 1 0 0",
                                 tb_if.scan_enable, tb_if.cmd_ready, tb_if.busy, tb_if.scan_ck_enable);
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        tb_if.cmd_valid = 1'b0;
        tb_if.cmd_op    = 2'd0;
        tb_if.cmd_len   = '0;
        tb_if.abort     = 1'b0;
        tb_if.in_data   = 32'd0;
        tb_if.in_valid  = 1'b0;
        tb_if.out_ready = 1'b1;
        test_reset();
        test_dump();
        test_load();
        test_swap_backpressure();
        test_zero_len_and_reserved();
        test_abort();
        test_back_to_back();
`ifdef SCAN_CTRL_CRC_EN
        test_crc();
`endif
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
